counter_dozens_units: RTL and testbench



---
 rtl/counter_dozens_units.sv | 144 ++++++++++++++
 tb/tb_counter_dozens_units.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_dozens_units.sv
// Two-digit BCD up/down timer (dozens:units) stepping once every TICK_DIV cycles, with start/pause/clear.
// All outputs registered; the loaded count and running are visible one edge after start; there is no backpressure.
module counter_dozens_units #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned LIMIT_DOZENS = 2,
  parameter int unsigned LIMIT_UNITS  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       up_down,
  output logic [1:0] dozens,
  output logic [3:0] units,
  output logic       running,
  output logic       done
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0]    LIM_DZ     = 2'(LIMIT_DOZENS);
  localparam logic [3:0]    LIM_UN     = 4'(LIMIT_UNITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    dozens_q, dozens_d;
  logic [3:0]    units_q, units_d;
  logic          dir_q, dir_d;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic [1:0]    step_dz;
  logic [3:0]    step_un;
  logic          at_term;

  // Candidate next count for one step in the latched direction, and whether it is terminal.
  always_comb begin
    step_dz = dozens_q;
    step_un = units_q;
    if (!dir_q) begin
      if (units_q == 4'd9) begin
        step_un = 4'd0;
        step_dz = dozens_q + 2'd1;
      end else begin
        step_un = units_q + 4'd1;
      end
    end else begin
      if (units_q == 4'd0) begin
        step_un = 4'd9;
        step_dz = dozens_q - 2'd1;
      end else begin
        step_un = units_q - 4'd1;
      end
    end
    at_term = dir_q ? ((step_dz == 2'd0) && (step_un == 4'd0))
                    : ((step_dz == LIM_DZ) && (step_un == LIM_UN));
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    dozens_d = dozens_q;
    units_d  = units_q;
    dir_d    = dir_q;
    done_d   = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      presc_d  = '0;
      dozens_d = 2'd0;
      units_d  = 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_RUN;
            presc_d  = '0;
            dir_d    = up_down;
            dozens_d = up_down ? LIM_DZ : 2'd0;
            units_d  = up_down ? LIM_UN : 4'd0;
          end
        end
        ST_RUN: begin
          // Pausing suppresses any step due on this edge; it happens after resume instead.
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d  = '0;
            dozens_d = step_dz;
            units_d  = step_un;
            if (at_term) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (pause || start) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      dozens_q  <= 2'd0;
      units_q   <= 4'd0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dozens_q  <= dozens_d;
      units_q   <= units_d;
      dir_q     <= dir_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign dozens  = dozens_q;
  assign units   = units_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_counter_dozens_units.sv
// Directed bench: instance A (TICK_DIV=4, limit 29) and instance B (TICK_DIV=1, limit 03).
module tb_counter_dozens_units;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_start, a_pause, a_clear, a_up_down;
  logic [1:0] a_dozens;
  logic [3:0] a_units;
  logic       a_running, a_done;
  logic       b_start, b_pause, b_clear, b_up_down;
  logic [1:0] b_dozens;
  logic [3:0] b_units;
  logic       b_running, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_dozens_units #(.TICK_DIV(4), .LIMIT_DOZENS(2), .LIMIT_UNITS(9)) u_dut_a (
    .clk     (clk),
    .reset   (reset),
    .start   (a_start),
    .pause   (a_pause),
    .clear   (a_clear),
    .up_down (a_up_down),
    .dozens  (a_dozens),
    .units   (a_units),
    .running (a_running),
    .done    (a_done)
  );

  counter_dozens_units #(.TICK_DIV(1), .LIMIT_DOZENS(0), .LIMIT_UNITS(3)) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .start   (b_start),
    .pause   (b_pause),
    .clear   (b_clear),
    .up_down (b_up_down),
    .dozens  (b_dozens),
    .units   (b_units),
    .running (b_running),
    .done    (b_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int val, input int run, input int dn);
    check_val({tag, ".dozens"}, 32'(a_dozens), 32'(val / 10));
    check_val({tag, ".units"}, 32'(a_units), 32'(val % 10));
    check_val({tag, ".running"}, 32'(a_running), 32'(run));
    check_val({tag, ".done"}, 32'(a_done), 32'(dn));
  endtask

  task automatic chk_b(input string tag, input int val, input int run, input int dn);
    check_val({tag, ".dozens"}, 32'(b_dozens), 32'(val / 10));
    check_val({tag, ".units"}, 32'(b_units), 32'(val % 10));
    check_val({tag, ".running"}, 32'(b_running), 32'(run));
    check_val({tag, ".done"}, 32'(b_done), 32'(dn));
  endtask

  initial begin
    reset = 1'b1;
    {a_start, a_pause, a_clear, a_up_down} = '0;
    {b_start, b_pause, b_clear, b_up_down} = '0;
    tick();
    tick();
    chk_a("a_reset", 0, 0, 0);
    chk_b("b_reset", 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_a("a_idle", 0, 0, 0);

    // Up run 00 -> 29, one step every 4 cycles.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk_a("up_load", 0, 1, 0);
    for (int k = 1; k <= 29; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk_a($sformatf("up_hold%0d", k - 1), k - 1, 1, 0);
      end
      tick();
      chk_a($sformatf("up_step%0d", k), k, (k != 29) ? 1 : 0, (k == 29) ? 1 : 0);
    end
    for (int j = 0; j < 5; j++) begin
      tick();
      chk_a("up_done_hold", 29, 0, 0);
    end

    // Down run 29 -> 00; direction cleared after start to show it is latched.
    a_up_down = 1'b1;
    a_start   = 1'b1;
    tick();
    a_start   = 1'b0;
    a_up_down = 1'b0;
    chk_a("dn_load", 29, 1, 0);
    for (int k = 28; k >= 0; k--) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk_a($sformatf("dn_hold%0d", k + 1), k + 1, 1, 0);
      end
      tick();
      chk_a($sformatf("dn_step%0d", k), k, (k != 0) ? 1 : 0, (k == 0) ? 1 : 0);
    end
    tick();
    chk_a("dn_done_hold", 0, 0, 0);

    // Pause at 05 after two prescale cycles, resume with start.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk_a("p_load", 0, 1, 0);
    for (int k = 1; k <= 5; k++) repeat (4) tick();
    chk_a("p_at05", 5, 1, 0);
    tick();
    tick();
    a_pause = 1'b1;
    tick();
    a_pause = 1'b0;
    chk_a("p_paused", 5, 0, 0);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk_a("p_frozen", 5, 0, 0);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk_a("p_resume", 5, 1, 0);
    tick();
    chk_a("p_resume1", 5, 1, 0);
    tick();
    chk_a("p_resume2", 6, 1, 0);
    repeat (3) tick();
    chk_a("p_cadence_hold", 6, 1, 0);
    tick();
    chk_a("p_cadence_step", 7, 1, 0);

    // Clear on the edge that would step 28 -> 29.
    for (int k = 8; k <= 28; k++) repeat (4) tick();
    chk_a("c_at28", 28, 1, 0);
    repeat (3) tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk_a("c_cleared", 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk_a("c_idle", 0, 0, 0);
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk_a("c_restart", 0, 1, 0);
    repeat (4) tick();
    chk_a("c_restart_step", 1, 1, 0);

    // Reset mid-run at 17, with start held high during reset.
    for (int k = 2; k <= 17; k++) repeat (4) tick();
    chk_a("r_at17", 17, 1, 0);
    tick();
    reset   = 1'b1;
    a_start = 1'b1;
    tick();
    chk_a("r_reset1", 0, 0, 0);
    tick();
    chk_a("r_reset2", 0, 0, 0);
    reset   = 1'b0;
    a_start = 1'b0;
    tick();
    chk_a("r_after", 0, 0, 0);

    // TICK_DIV=1, limit 03: up run then down run from DONE.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk_b("b_up_load", 0, 1, 0);
    tick();
    chk_b("b_up1", 1, 1, 0);
    tick();
    chk_b("b_up2", 2, 1, 0);
    tick();
    chk_b("b_up3", 3, 0, 1);
    tick();
    chk_b("b_up_hold", 3, 0, 0);
    b_up_down = 1'b1;
    b_start   = 1'b1;
    tick();
    b_start   = 1'b0;
    b_up_down = 1'b0;
    chk_b("b_dn_load", 3, 1, 0);
    tick();
    chk_b("b_dn2", 2, 1, 0);
    tick();
    chk_b("b_dn1", 1, 1, 0);
    tick();
    chk_b("b_dn0", 0, 0, 1);
    tick();
    chk_b("b_dn_hold", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
